ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port Clk, input, 1, the single rising-edge clock.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have inputs ControlsIn 8, Data1In 16, Data2In 16, JEQAddrIn 16, JMPAddrIn 16, Imm8In 8, Reg1In 3, Reg2In 3, driven by the ID/EX register outputs.
REQ-004 SHALL decode ControlsIn as [7] RegWrite, [6] MemRead, [5] MemWrite, [4] JEQ, [3] JMP, [2:0] AluOp; Reg1In is rs1 and rd, Reg2In is rs2.
REQ-005 SHALL have inputs WbRegWrite 1, WbReg 3, WbData 16: the MEM/WB write-back port, used for forwarding.
REQ-006 SHALL have outputs PcRedirect 1, PcTarget 16, Flush 1, Stall 1, all combinational.
REQ-007 SHALL have registered outputs MemCtrlOut 3 ({RegWrite,MemRead,MemWrite}), AluResultOut 16, StoreDataOut 16, DestRegOut 3: the EX/MEM register.

Function
REQ-008 AluOp encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL (A << B[3:0]), 110 LDI (zero-extended Imm8), 111 MUL.
REQ-009 Operand A SHALL come from the forwarding selection for rs1: EX/MEM (MemCtrlOut[2], DestRegOut==Reg1In, MemRead=0) first, then WB (WbRegWrite, WbReg==Reg1In), else Data1In.
REQ-010 Operand B SHALL be the forwarded rs2 value, selected by the same rule, except when MemRead or MemWrite is set; then B is sign-extended Imm8.
REQ-011 StoreDataOut SHALL capture the forwarded rs2 value.
REQ-012 All arithmetic SHALL be 16-bit, wrap-around, with no carry or overflow output.
REQ-013 JEQ with forwarded A==rs2 value SHALL assert PcRedirect, with PcTarget=JEQAddrIn; JMP SHALL always redirect to JMPAddrIn; JMP SHALL win if both bits are set.
REQ-014 Flush SHALL equal PcRedirect, and Flush SHALL be forced to 0 while Stall=1.
REQ-015 MUL FSM states SHALL be IDLE, BUSY, DONE.
REQ-016 In IDLE with AluOp=111 and RegWrite=1, the block SHALL latch A and B, clear the product and counter, assert Stall, and go to BUSY.
REQ-017 In BUSY, the block SHALL perform one shift-add step per cycle and hold Stall=1; after 16 steps (counter=15) it SHALL go to DONE.
REQ-018 In DONE, Stall SHALL be 0, EX/MEM SHALL capture the low 16 bits of the product, and the FSM SHALL return to IDLE unconditionally.
REQ-019 MUL latency: Stall high for 17 cycles; the result SHALL be present in EX/MEM 18 edges after the MUL enters ID/EX.
REQ-020 While Stall=1, EX/MEM SHALL load a bubble (all fields 0).
REQ-021 Non-MUL ops SHALL have single-cycle latency: the EX/MEM register updates on every edge with Stall=0.
REQ-022 A JEQ or JMP SHALL load a bubble into MemCtrlOut (no write, no memory access).
REQ-023 Operand latching at IDLE SHALL use forwarded values, so a MUL dependent on the preceding instruction is correct.

Reset
REQ-024 Reset SHALL asynchronously clear EX/MEM to 0, the FSM to IDLE, and the counter and product to 0.
REQ-025 Reset during BUSY SHALL abandon the multiply with no result written.
REQ-026 After Reset deasserts, Stall, Flush and PcRedirect SHALL be 0 while the inputs are 0.

Structure
REQ-027 The AluOp codes, control-bit indices, FSM state encoding and widths (16 data, 3 reg, 8 ctrl) SHALL live in the shared cpu package.
REQ-028 The shift-add multiplier SHALL be one sub-module, ex_mul_seq (start, a, b -> busy, done, product).

Verification
REQ-029 ADD with Data1=0x7FFF, Data2=0x0001 -> AluResultOut=0x8000 one edge later; SUB 0x0000-0x0001 -> 0xFFFF.
REQ-030 Back-to-back ADD r1 then ADD r2,r1 with stale Data1In=0 -> the second uses the EX/MEM value; with WbReg=r1, WbData=5 as well, EX/MEM still wins.
REQ-031 JEQ with forwarded A=B=0x1234, JEQAddr=0x0040 -> PcRedirect=1, PcTarget=0x0040, Flush=1, MemCtrlOut=0 next edge; A≠B -> no redirect.
REQ-032 MUL 0x0123×0x0010 -> Stall high 17 cycles, EX/MEM bubbles during them, then AluResultOut=0x1230, RegWrite=1.
REQ-033 Reset asserted mid-BUSY (cycle 8) -> outputs 0 immediately, FSM IDLE; after release, a following ADD completes normally.
REQ-034 Load with Data1=0x0100, Imm8=0xFE -> AluResultOut=0x00FE (sign-extended −2 added), MemCtrlOut=3'b110.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the execute stage and its multiplier.
// Holds datapath widths, ControlsIn bit positions, the ALU opcode encoding,
// the multiplier FSM state encoding and a small sign-extension helper.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int CTRL_W = 8;
  localparam int IMM_W  = 8;
  localparam int CNT_W  = 4;

  // ControlsIn bit positions
  localparam int CTRL_REG_WRITE = 7;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_MEM_WRITE = 5;
  localparam int CTRL_JEQ       = 4;
  localparam int CTRL_JMP       = 3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_LDI = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] v);
    return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/ex_mul_seq.sv
// Sequential 16x16 shift-add multiplier, low 16 bits of the product kept.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request; sampled only in IDLE, latches a/b
//   a, b       : operands
//   busy       : high for the 16 step cycles
//   done       : high for one cycle after the last step, product is valid
//   product    : low 16 bits of a*b
//   state_o    : FSM state, exported for debug/observation
//
// Protocol: start is a level request. In IDLE a high start latches the
// operands and moves to BUSY; done pulses for exactly one cycle, after which
// the FSM is back in IDLE and will accept a new start on the next cycle.
module ex_mul_seq
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product,
  output mul_state_e        state_o
);

  mul_state_e        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MUL_IDLE: if (start) state_d = MUL_BUSY;
      MUL_BUSY: if (cnt_q == {CNT_W{1'b1}}) state_d = MUL_DONE;
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  // Datapath: each BUSY cycle consumes one multiplier bit (LSB first) while
  // the multiplicand shifts left, so bit i contributes a << i.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    prod_d = prod_q;
    cnt_d  = cnt_q;
    if (state_q == MUL_IDLE && start) begin
      a_d    = a;
      b_d    = b;
      prod_d = '0;
      cnt_d  = '0;
    end else if (state_q == MUL_BUSY) begin
      if (b_q[0]) prod_d = prod_q + a_q;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output logic
  always_comb begin
    busy = (state_q == MUL_BUSY);
    done = (state_q == MUL_DONE);
  end

  assign product = prod_q;
  assign state_o = state_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, sequential MUL
// and the EX/MEM pipeline register.
// Ports:
//   Clk, Reset            : clock, asynchronous active-high reset
//   ControlsIn..Reg2In    : ID/EX register contents (Reg1In = rs1/rd, Reg2In = rs2)
//   WbRegWrite/WbReg/WbData : MEM/WB write-back port, used as forwarding source
//   PcRedirect, PcTarget  : combinational branch/jump resolution
//   Flush                 : squash younger instructions (suppressed while stalled)
//   Stall                 : hold upstream stages; EX/MEM takes a bubble meanwhile
//   MemCtrlOut..DestRegOut: EX/MEM register ({RegWrite,MemRead,MemWrite}, result,
//                           store data, destination register)
module ex_stage
  import cpu_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [CTRL_W-1:0] ControlsIn,
  input  logic [DATA_W-1:0] Data1In,
  input  logic [DATA_W-1:0] Data2In,
  input  logic [DATA_W-1:0] JEQAddrIn,
  input  logic [DATA_W-1:0] JMPAddrIn,
  input  logic [IMM_W-1:0]  Imm8In,
  input  logic [REG_W-1:0]  Reg1In,
  input  logic [REG_W-1:0]  Reg2In,
  input  logic              WbRegWrite,
  input  logic [REG_W-1:0]  WbReg,
  input  logic [DATA_W-1:0] WbData,
  output logic              PcRedirect,
  output logic [DATA_W-1:0] PcTarget,
  output logic              Flush,
  output logic              Stall,
  output logic [2:0]        MemCtrlOut,
  output logic [DATA_W-1:0] AluResultOut,
  output logic [DATA_W-1:0] StoreDataOut,
  output logic [REG_W-1:0]  DestRegOut
);

  logic              reg_write, mem_read, mem_write, is_jeq, is_jmp;
  alu_op_e           alu_op;
  logic              exmem_fwd_ok;
  logic [DATA_W-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_result;
  logic              mul_req, mul_busy, mul_done, stall;
  logic [DATA_W-1:0] mul_product;
  mul_state_e        mul_state;

  logic [2:0]        mem_ctrl_q, mem_ctrl_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  logic [REG_W-1:0]  dest_reg_q, dest_reg_d;

  assign reg_write = ControlsIn[CTRL_REG_WRITE];
  assign mem_read  = ControlsIn[CTRL_MEM_READ];
  assign mem_write = ControlsIn[CTRL_MEM_WRITE];
  assign is_jeq    = ControlsIn[CTRL_JEQ];
  assign is_jmp    = ControlsIn[CTRL_JMP];
  assign alu_op    = alu_op_e'(ControlsIn[2:0]);

  // A load in EX/MEM has no data yet, so it is never a forwarding source.
  assign exmem_fwd_ok = mem_ctrl_q[2] & ~mem_ctrl_q[1];

  // Forwarding priority: EX/MEM (youngest) over write-back over register file.
  always_comb begin
    fwd_rs1 = Data1In;
    if (exmem_fwd_ok && dest_reg_q == Reg1In)  fwd_rs1 = alu_result_q;
    else if (WbRegWrite && WbReg == Reg1In)    fwd_rs1 = WbData;
    fwd_rs2 = Data2In;
    if (exmem_fwd_ok && dest_reg_q == Reg2In)  fwd_rs2 = alu_result_q;
    else if (WbRegWrite && WbReg == Reg2In)    fwd_rs2 = WbData;
  end

  // Memory ops compute base + signed 8-bit offset.
  assign op_a = fwd_rs1;
  assign op_b = (mem_read | mem_write) ? sext_imm(Imm8In) : fwd_rs2;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = op_a + op_b;
      ALU_SUB: alu_result = op_a - op_b;
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_XOR: alu_result = op_a ^ op_b;
      ALU_SHL: alu_result = op_a << op_b[3:0];
      ALU_LDI: alu_result = {{(DATA_W-IMM_W){1'b0}}, Imm8In};
      ALU_MUL: alu_result = '0; // result comes from the multiplier
      default: alu_result = '0;
    endcase
  end

  assign mul_req = (alu_op == ALU_MUL) & reg_write;

  ex_mul_seq u_mul (
    .clk     (Clk),
    .rst     (Reset),
    .start   (mul_req),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product),
    .state_o (mul_state)
  );

  // Stall covers the IDLE cycle that launches the multiply plus all BUSY
  // cycles; the DONE cycle releases the pipeline and writes the product.
  assign stall = mul_busy | (mul_req & (mul_state == MUL_IDLE));
  assign Stall = stall;

  // JMP takes priority over JEQ.
  assign PcRedirect = is_jmp | (is_jeq & (fwd_rs1 == fwd_rs2));
  assign PcTarget   = is_jmp ? JMPAddrIn : JEQAddrIn;
  assign Flush      = PcRedirect & ~stall;

  // EX/MEM next value: bubble while stalled; jumps never write or touch memory.
  always_comb begin
    mem_ctrl_d   = '0;
    alu_result_d = '0;
    store_data_d = '0;
    dest_reg_d   = '0;
    if (!stall) begin
      mem_ctrl_d   = (is_jeq | is_jmp) ? 3'b000 : {reg_write, mem_read, mem_write};
      alu_result_d = mul_done ? mul_product : alu_result;
      store_data_d = fwd_rs2;
      dest_reg_d   = Reg1In;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mem_ctrl_q   <= '0;
      alu_result_q <= '0;
      store_data_q <= '0;
      dest_reg_q   <= '0;
    end else begin
      mem_ctrl_q   <= mem_ctrl_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      dest_reg_q   <= dest_reg_d;
    end
  end

  assign MemCtrlOut   = mem_ctrl_q;
  assign AluResultOut = alu_result_q;
  assign StoreDataOut = store_data_q;
  assign DestRegOut   = dest_reg_q;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import cpu_pkg::*;

  logic        Clk, Reset;
  logic [7:0]  ControlsIn;
  logic [15:0] Data1In, Data2In, JEQAddrIn, JMPAddrIn;
  logic [7:0]  Imm8In;
  logic [2:0]  Reg1In, Reg2In;
  logic        WbRegWrite;
  logic [2:0]  WbReg;
  logic [15:0] WbData;
  logic        PcRedirect, Flush, Stall;
  logic [15:0] PcTarget;
  logic [2:0]  MemCtrlOut;
  logic [15:0] AluResultOut, StoreDataOut;
  logic [2:0]  DestRegOut;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .ControlsIn   (ControlsIn),
    .Data1In      (Data1In),
    .Data2In      (Data2In),
    .JEQAddrIn    (JEQAddrIn),
    .JMPAddrIn    (JMPAddrIn),
    .Imm8In       (Imm8In),
    .Reg1In       (Reg1In),
    .Reg2In       (Reg2In),
    .WbRegWrite   (WbRegWrite),
    .WbReg        (WbReg),
    .WbData       (WbData),
    .PcRedirect   (PcRedirect),
    .PcTarget     (PcTarget),
    .Flush        (Flush),
    .Stall        (Stall),
    .MemCtrlOut   (MemCtrlOut),
    .AluResultOut (AluResultOut),
    .StoreDataOut (StoreDataOut),
    .DestRegOut   (DestRegOut)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] ctrl, input logic [15:0] d1, input logic [15:0] d2,
                       input logic [2:0] r1, input logic [2:0] r2, input logic [7:0] imm);
    ControlsIn = ctrl;
    Data1In    = d1;
    Data2In    = d2;
    Reg1In     = r1;
    Reg2In     = r2;
    Imm8In     = imm;
  endtask

  task automatic wb(input logic en, input logic [2:0] r, input logic [15:0] d);
    WbRegWrite = en;
    WbReg      = r;
    WbData     = d;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_exmem(input string tag, input logic [2:0] ctrl, input logic [15:0] res,
                           input logic [2:0] dst);
    chk({tag, "_ctrl"}, 16'(MemCtrlOut), 16'(ctrl));
    chk({tag, "_res"},  AluResultOut, res);
    chk({tag, "_dst"},  16'(DestRegOut), 16'(dst));
  endtask

  initial begin
    Reset = 1'b1;
    drive(8'h00, 16'h0, 16'h0, 3'd0, 3'd0, 8'h00);
    wb(1'b0, 3'd0, 16'h0);
    JEQAddrIn = 16'h0;
    JMPAddrIn = 16'h0;

    // Reset state
    tick();
    tick();
    chk_exmem("rst", 3'b000, 16'h0000, 3'd0);
    chk("rst_store", StoreDataOut, 16'h0000);
    Reset = 1'b0;
    #1;
    chk("rst_stall", 16'(Stall), 16'h0);
    chk("rst_flush", 16'(Flush), 16'h0);
    chk("rst_redirect", 16'(PcRedirect), 16'h0);

    // ADD wraps into the sign bit
    drive(8'h80, 16'h7FFF, 16'h0001, 3'd1, 3'd2, 8'h00);
    tick();
    chk_exmem("add", 3'b100, 16'h8000, 3'd1);

    // SUB 0 - 1
    drive(8'h81, 16'h0000, 16'h0001, 3'd3, 3'd4, 8'h00);
    tick();
    chk_exmem("sub", 3'b100, 16'hFFFF, 3'd3);

    // ADD r1 = 0x10 + 0x20
    drive(8'h80, 16'h0010, 16'h0020, 3'd1, 3'd2, 8'h00);
    tick();
    chk_exmem("add_r1", 3'b100, 16'h0030, 3'd1);

    // Dependent ADD on r1 (rs2): EX/MEM beats WB
    drive(8'h80, 16'h0003, 16'h0000, 3'd2, 3'd1, 8'h00);
    wb(1'b1, 3'd1, 16'h0005);
    tick();
    chk_exmem("fwd_exmem", 3'b100, 16'h0033, 3'd2);
    chk("fwd_exmem_store", StoreDataOut, 16'h0030);

    // WB forward on rs1 (OR)
    drive(8'h83, 16'h0000, 16'h000F, 3'd4, 3'd5, 8'h00);
    wb(1'b1, 3'd4, 16'h0100);
    tick();
    chk_exmem("fwd_wb", 3'b100, 16'h010F, 3'd4);
    wb(1'b0, 3'd0, 16'h0000);

    // EX/MEM forward on rs1 (XOR)
    drive(8'h84, 16'hFFFF, 16'h00FF, 3'd4, 3'd6, 8'h00);
    tick();
    chk_exmem("xor_fwd", 3'b100, 16'h01F0, 3'd4);

    // AND
    drive(8'h82, 16'hF0F0, 16'h3C3C, 3'd5, 3'd6, 8'h00);
    tick();
    chk_exmem("and", 3'b100, 16'h3030, 3'd5);

    // SHL uses only B[3:0]
    drive(8'h85, 16'h0001, 16'h0013, 3'd6, 3'd7, 8'h00);
    tick();
    chk_exmem("shl", 3'b100, 16'h0008, 3'd6);

    // LDI zero-extends
    drive(8'h86, 16'h1111, 16'h2222, 3'd7, 3'd0, 8'hFE);
    tick();
    chk_exmem("ldi", 3'b100, 16'h00FE, 3'd7);

    // Load: 0x0100 + sext(0xFE)
    drive(8'hC0, 16'h0100, 16'h0000, 3'd1, 3'd2, 8'hFE);
    tick();
    chk_exmem("load", 3'b110, 16'h00FE, 3'd1);

    // Load in EX/MEM must not forward
    drive(8'h80, 16'h0002, 16'h0003, 3'd1, 3'd3, 8'h00);
    tick();
    chk_exmem("no_fwd_load", 3'b100, 16'h0005, 3'd1);

    // Store: address = base + imm, data = rs2
    drive(8'h20, 16'h1000, 16'hBEEF, 3'd2, 3'd3, 8'h04);
    tick();
    chk_exmem("store", 3'b001, 16'h1004, 3'd2);
    chk("store_data", StoreDataOut, 16'hBEEF);

    // JEQ taken
    JEQAddrIn = 16'h0040;
    JMPAddrIn = 16'h0999;
    drive(8'h10, 16'h1234, 16'h1234, 3'd1, 3'd2, 8'h00);
    #1;
    chk("jeq_redirect", 16'(PcRedirect), 16'h1);
    chk("jeq_target", PcTarget, 16'h0040);
    chk("jeq_flush", 16'(Flush), 16'h1);
    chk("jeq_stall", 16'(Stall), 16'h0);
    tick();
    chk("jeq_bubble", 16'(MemCtrlOut), 16'h0);

    // JEQ not taken
    drive(8'h10, 16'h1234, 16'h1235, 3'd1, 3'd2, 8'h00);
    #1;
    chk("jne_redirect", 16'(PcRedirect), 16'h0);
    chk("jne_flush", 16'(Flush), 16'h0);
    tick();

    // JMP wins over JEQ
    drive(8'h18, 16'h1234, 16'h1234, 3'd1, 3'd2, 8'h00);
    #1;
    chk("jmp_jeq_redirect", 16'(PcRedirect), 16'h1);
    chk("jmp_jeq_target", PcTarget, 16'h0999);
    tick();

    // JMP with RegWrite set still loads a bubble
    drive(8'h88, 16'h0000, 16'h0000, 3'd3, 3'd4, 8'h00);
    #1;
    chk("jmp_redirect", 16'(PcRedirect), 16'h1);
    tick();
    chk("jmp_bubble", 16'(MemCtrlOut), 16'h0);

    // MUL 0x0123 * 0x0010: 17 stall cycles with bubbles, result on edge 18
    drive(8'h87, 16'h0123, 16'h0010, 3'd1, 3'd2, 8'h00);
    for (int i = 0; i < 17; i++) begin
      #1;
      chk($sformatf("mul_stall_%0d", i), 16'(Stall), 16'h1);
      chk($sformatf("mul_flush_%0d", i), 16'(Flush), 16'h0);
      tick();
      chk($sformatf("mul_bubble_ctrl_%0d", i), 16'(MemCtrlOut), 16'h0);
      chk($sformatf("mul_bubble_res_%0d", i), AluResultOut, 16'h0);
    end
    #1;
    chk("mul_done_stall", 16'(Stall), 16'h0);
    tick();
    chk_exmem("mul", 3'b100, 16'h1230, 3'd1);

    // Dependent MUL: rs2 = r1 forwarded from EX/MEM at launch
    drive(8'h87, 16'h0002, 16'h0000, 3'd3, 3'd1, 8'h00);
    for (int i = 0; i < 17; i++) tick();
    #1;
    chk("mul_dep_stall", 16'(Stall), 16'h0);
    tick();
    chk_exmem("mul_dep", 3'b100, 16'h2460, 3'd3);

    // Reset in the middle of a multiply
    drive(8'h87, 16'h0005, 16'h0007, 3'd4, 3'd5, 8'h00);
    for (int i = 0; i < 8; i++) tick();
    chk("mul_mid_busy", 16'(Stall), 16'h1);
    Reset = 1'b1;
    #1;
    chk_exmem("rst_busy", 3'b000, 16'h0000, 3'd0);
    chk("rst_busy_state", 16'(dut.u_mul.state_o), 16'(MUL_IDLE));
    drive(8'h80, 16'h0004, 16'h0005, 3'd1, 3'd2, 8'h00);
    #1;
    Reset = 1'b0;
    #1;
    chk("post_rst_stall", 16'(Stall), 16'h0);
    tick();
    chk_exmem("post_rst_add", 3'b100, 16'h0009, 3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
